bsg_gateway_mem_link_wh_arbiter: RTL and testbench
==================================================

// Module: bsg_gateway_mem_link_wh_arbiter
// PURPOSE
//  Packet-aware N:1 arbiter that shares one concentrated gateway memory link among num_in_p
//  wormhole request links feeding the wormhole test memory. Round-robin is decided only at
//  header flits; the grant is held for the entire packet (header + len body flits), so
//  packets from different vcache links never interleave. Forward (request) direction only.
// PARAMETERS
//  width_p       = 32  flit width in bits (mem_link_width_gp)
//  num_in_p      = 2   requesting links (mem_link_rr_ratio_gp); must be >= 1
//  len_width_p   = 4   header len field width (wh_len_width_gp)
//  len_offset_p  = 8   LSB position of the len field within the header flit
// PORTS
//  clk_i            in   1                    gateway hb clock
//  reset_i          in   1                    synchronous, active-high reset
//  in_v_i           in   num_in_p             per-link flit valid
//  in_data_i        in   num_in_p*width_p     per-link flit data; link i at [i*width_p+:width_p]
//  in_ready_and_o   out  num_in_p             per-link ready (ready&valid handshake)
//  out_v_o          out  1                    concentrated link valid
//  out_data_o       out  width_p              concentrated link data
//  out_ready_and_i  in   1                    concentrated link ready
//  stats_o          out  num_in_p*32          per-link packet counts (only with the macro)
// BEHAVIOUR
//  - Handshake on any link = v & ready_and in the same cycle. Data path is combinational,
//    zero cycles of latency; out_data_o = in_data_i[sel]. No output depends on out_ready_and_i
//    other than in_ready_and_o[sel].
//  - State machine with two states, IDLE and LOCK:
//    IDLE: sel = first i with in_v_i[i], searching from ptr_r upward and wrapping modulo
//      num_in_p. out_v_o = |in_v_i. in_ready_and_o[sel] = out_ready_and_i. All other readies = 0.
//      On a handshake, the header len field L = data[len_offset_p+:len_width_p] is read, then:
//      ptr_r <= (sel+1) mod num_in_p and sel_r <= sel. If L==0, stay in IDLE.
//      If L!=0, go to LOCK with cnt_r <= L.
//    LOCK: sel = sel_r. out_v_o = in_v_i[sel_r]. Only sel_r may be ready. Each handshake
//      decrements cnt_r. A handshake with cnt_r==1 returns to IDLE. In LOCK, inputs from
//      other links are ignored, even when the locked link is stalled (in_v_i[sel_r]==0).
//  - No valid inputs in IDLE: out_v_o=0, all readies 0, state and ptr_r unchanged.
//  - out_ready_and_i=0: no handshake occurs; state, ptr_r and cnt_r hold. sel may still
//    change in IDLE because the flit was not consumed.
//  - len all-ones: 2^len_width_p-1 body flits. cnt_r is len_width_p bits wide and never
//    underflows.
//  - Reset, including mid-packet: state=IDLE, ptr_r=0, sel_r=0, cnt_r=0, stats cleared.
//    While reset_i is high: out_v_o=0 and in_ready_and_o=0. The upstream must reset too;
//    partial packets are not recovered.
//  - num_in_p==1: ptr_r is constant 0. The lock logic still counts flits.
// CONFIGURATION
//  `BSG_GATEWAY_MEM_ARB_STATS_EN defined: one 32-bit counter per link, incremented on each
//    header handshake for that link. The counter saturates at 32'hFFFF_FFFF. Counters are
//    driven on stats_o.
//  Macro not defined: no counters are built, and stats_o is tied to '0 (the port stays).
// STRUCTURE
//  - bsg_chip_pkg: mem_link_width_gp, mem_link_rr_ratio_gp and wh_len_width_gp supply
//    the defaults. Add localparam mem_link_len_offset_gp to the package.
//  - The state enum {IDLE, LOCK} is local to this module.
//  - One sub-module: basejump bsg_arb_round_robin, used for header selection.
//    Its yumi_i = header handshake in IDLE.
//  - Counter, lock and mux logic are inline.
//  - In bsg_gateway_chip_core_complex this block replaces bsg_ready_and_link_round_robin_static
//    on the request path.
// TESTING (num_in_p=2, len_width_p=4, len_offset_p=8)
//  - Single packet: link0 sends a header with L=3, then 3 body flits, out_ready=1.
//    -> 4 out flits in 4 consecutive cycles; state returns to IDLE; ptr_r=1.
//  - Contention: both links send L=2 packets continuously. -> out order is
//    0,0,0,1,1,1,0,0,0; no interleaving.
//  - Stalled lock: link0 sends a header with L=2, then drops valid for 5 cycles while link1
//    is valid. -> out_v_o=0 and in_ready_and_o[1]=0 for those 5 cycles; link0's body then
//    completes.
//  - Backpressure: out_ready toggles 1,0,1,0 during an L=4 packet. -> each flit appears
//    exactly once; cnt_r decrements only on handshake cycles.
//  - Zero-length and reset: an L=0 header from each link alternates 0,1,0,1. Assert reset_i
//    mid-way through an L=5 packet. -> IDLE, ptr_r=0, out_v_o=0 during reset; after reset,
//    link0 is granted first.
//  - Stats (macro on): 7 packets on link0 and 3 on link1. -> stats_o = {32'd3, 32'd7}.
//    Macro off: stats_o = 0.

Source files
------------

// File: rtl/bsg_chip_pkg.sv
// Chip-level link parameters shared by the gateway memory-link blocks.
package bsg_chip_pkg;

  localparam int mem_link_width_gp      = 32;
  localparam int mem_link_rr_ratio_gp   = 2;
  localparam int wh_len_width_gp        = 4;
  localparam int mem_link_len_offset_gp = 8;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin request selector; priority rotates to just past the last accepted grant.
module bsg_arb_round_robin #(
  parameter int width_p = 2,
  localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     reqs_i,
  output logic [width_p-1:0]     grants_o,
  output logic [lg_width_lp-1:0] sel_o,
  input  logic                   yumi_i
);

  logic [lg_width_lp-1:0] ptr_r;
  logic                   found;
  int                     j;

  always_comb begin
    sel_o    = ptr_r;
    grants_o = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < width_p; k++) begin
      j = int'(ptr_r) + k;
      if (j >= width_p) j = j - width_p;
      if (!found && reqs_i[j]) begin
        found       = 1'b1;
        sel_o       = lg_width_lp'(j);
        grants_o[j] = 1'b1;
      end
    end
  end

  // With a single requester sel_o is always 0, so ptr_r stays 0.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      ptr_r <= '0;
    else if (yumi_i)
      ptr_r <= (int'(sel_o) == width_p - 1) ? '0 : sel_o + lg_width_lp'(1);
  end

endmodule

// File: rtl/bsg_gateway_mem_link_wh_arbiter.sv
// Packet-aware N:1 wormhole arbiter: round-robin at headers, grant held for the whole packet.
// Optional per-link header counters on stats_o when BSG_GATEWAY_MEM_ARB_STATS_EN is defined.
module bsg_gateway_mem_link_wh_arbiter
  import bsg_chip_pkg::*;
#(
  parameter int width_p      = mem_link_width_gp,
  parameter int num_in_p     = mem_link_rr_ratio_gp,
  parameter int len_width_p  = wh_len_width_gp,
  parameter int len_offset_p = mem_link_len_offset_gp
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_in_p-1:0]          in_v_i,
  input  logic [num_in_p*width_p-1:0]  in_data_i,
  output logic [num_in_p-1:0]          in_ready_and_o,
  output logic                         out_v_o,
  output logic [width_p-1:0]           out_data_o,
  input  logic                         out_ready_and_i,
  output logic [num_in_p*32-1:0]       stats_o
);

  localparam int lg_in_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]             state_r;
  logic [lg_in_lp-1:0]    sel_r, arb_sel, sel;
  logic [len_width_p-1:0] cnt_r, hdr_len;
  logic [num_in_p-1:0]    arb_grants;
  logic                   hs, hdr_hs;

  bsg_arb_round_robin #(.width_p(num_in_p)) arb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reqs_i   (in_v_i),
    .grants_o (arb_grants),
    .sel_o    (arb_sel),
    .yumi_i   (hdr_hs)
  );

  assign sel        = (state_r == LOCK) ? sel_r : arb_sel;
  assign out_data_o = in_data_i[int'(sel)*width_p +: width_p];
  assign hdr_len    = out_data_o[len_offset_p +: len_width_p];

  always_comb begin
    out_v_o        = 1'b0;
    in_ready_and_o = '0;
    if (!reset_i) begin
      if (state_r == IDLE) begin
        out_v_o        = |in_v_i;
        in_ready_and_o = arb_grants & {num_in_p{out_ready_and_i}};
      end else begin
        // Locked: other links are ignored even while the owner stalls.
        out_v_o               = in_v_i[sel_r];
        in_ready_and_o[sel_r] = out_ready_and_i;
      end
    end
  end

  assign hs     = out_v_o & out_ready_and_i;
  assign hdr_hs = hs & (state_r == IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      sel_r   <= '0;
      cnt_r   <= '0;
    end else if (hs) begin
      if (state_r == IDLE) begin
        sel_r <= arb_sel;
        if (hdr_len != '0) begin
          state_r <= LOCK;
          cnt_r   <= hdr_len;
        end
      end else begin
        cnt_r <= cnt_r - len_width_p'(1);
        if (cnt_r == len_width_p'(1)) state_r <= IDLE;
      end
    end
  end

`ifdef BSG_GATEWAY_MEM_ARB_STATS_EN
  logic [num_in_p-1:0][31:0] stats_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stats_r <= '0;
    end else begin
      for (int i = 0; i < num_in_p; i++) begin
        if (hdr_hs && (arb_sel == lg_in_lp'(i)) && (stats_r[i] != 32'hFFFF_FFFF))
          stats_r[i] <= stats_r[i] + 32'd1;
      end
    end
  end

  assign stats_o = stats_r;
`else
  assign stats_o = '0;
`endif

endmodule

// File: tb/tb_bsg_gateway_mem_link_wh_arbiter.sv
// Scoreboard bench: per-link drivers feed flit queues, a monitor pops expected output flits.
module tb_bsg_gateway_mem_link_wh_arbiter;

  localparam int W = 32;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_v = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic           out_v;
  logic [W-1:0]   out_data;
  logic           out_ready = 1'b1;
  logic [N*32-1:0] stats;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_q[$];
  logic        hold0 = 1'b0;

  bsg_gateway_mem_link_wh_arbiter #(
    .width_p(W), .num_in_p(N), .len_width_p(4), .len_offset_p(8)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .in_v_i         (in_v),
    .in_data_i      (in_data),
    .in_ready_and_o (in_ready),
    .out_v_o        (out_v),
    .out_data_o     (out_data),
    .out_ready_and_i(out_ready),
    .stats_o        (stats)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int link, input int pkt, input int len, input int idx);
    return {8'(link), 8'(pkt), 4'h0, 4'(len), 8'(idx)};
  endfunction

  // Body flits carry a nonzero len field so any re-arbitration mid-packet shows up.
  task automatic load(input int link, input int pkt, input int len);
    for (int i = 0; i <= len; i++) begin
      if (link == 0) q0.push_back(mk(0, pkt, (i == 0) ? len : 10, i));
      else           q1.push_back(mk(1, pkt, (i == 0) ? len : 10, i));
    end
  endtask

  task automatic expect_pkt(input int link, input int pkt, input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back(mk(link, pkt, (i == 0) ? len : 10, i));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #3;
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: timeout, %0d flits still expected", name, exp_q.size());
      exp_q.delete(); q0.delete(); q1.delete();
    end
  endtask

  // Link drivers: pop on the handshake seen before the edge, then present the next flit.
  initial begin
    logic [N-1:0] h;
    forever begin
      @(negedge clk);
      h = in_v & in_ready;
      @(posedge clk); #1;
      if (h[0] && q0.size() > 0) void'(q0.pop_front());
      if (h[1] && q1.size() > 0) void'(q1.pop_front());
      in_v[0]          = (q0.size() > 0) && !hold0;
      in_data[31:0]    = (q0.size() > 0) ? q0[0] : '0;
      in_v[1]          = (q1.size() > 0);
      in_data[63:32]   = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (out_v && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit: got %0h expected none", out_data);
        end else begin
          check("out_flit", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] stats_exp;
    int          n;
    bit          found;

    repeat (3) begin
      @(negedge clk);
      check("rst_out_v", out_v, 0);
      check("rst_ready", in_ready, 0);
    end
    check("rst_stats", stats, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("idle_no_valid", out_v, 0);

    // Contention from ptr=0: 0,0,0,1,1,1,0,0,0
    @(posedge clk); #2;
    load(0, 1, 2); load(0, 2, 2); load(1, 3, 2);
    expect_pkt(0, 1, 2); expect_pkt(1, 3, 2); expect_pkt(0, 2, 2);
    wait_idle("contention");

    // Single L=3 packet, four back-to-back flits
    @(posedge clk); #2;
    load(0, 4, 3);
    expect_pkt(0, 4, 3);
    repeat (5) @(posedge clk);
    #3;
    check("single_consecutive", exp_q.size(), 0);
    wait_idle("single");

    // Zero-length headers; ptr=1 after the single packet so link1 leads
    @(posedge clk); #2;
    load(0, 5, 0); load(0, 6, 0); load(1, 7, 0); load(1, 8, 0);
    expect_pkt(1, 7, 0); expect_pkt(0, 5, 0); expect_pkt(1, 8, 0); expect_pkt(0, 6, 0);
    wait_idle("zero_len");

    // Stalled lock: link0 header L=2, then link0 drops valid for 5 cycles while link1 waits
    @(posedge clk); #2;
    load(0, 9, 2);
    expect_pkt(0, 9, 2); expect_pkt(1, 10, 1);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_v[0] && in_ready[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("stall_hdr_seen", found, 1);
    hold0 = 1'b1;
    load(1, 10, 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_out_v", out_v, 0);
      check("stall_ready1", in_ready[1], 0);
    end
    hold0 = 1'b0;
    wait_idle("stall");

    // Backpressure during an L=4 packet; link1 must not cut in early
    @(posedge clk); #2;
    load(0, 11, 4); load(1, 12, 1);
    expect_pkt(0, 11, 4); expect_pkt(1, 12, 1);
    repeat (14) begin
      @(posedge clk); #1 out_ready = ~out_ready;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle("backpressure");

    // Reset two flits into an L=5 packet
    @(posedge clk); #2;
    load(0, 13, 5);
    exp_q.push_back(mk(0, 13, 5, 0));
    exp_q.push_back(mk(0, 13, 10, 1));
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (in_v[0] && in_ready[0]) n++;
    end
    check("rst_mid_progress", n, 2);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_out_v", out_v, 0);
      check("rst_mid_ready", in_ready, 0);
    end
    @(posedge clk); #2 q0.delete();
    @(posedge clk); #2 reset = 1'b0;
    check("rst_mid_flushed", exp_q.size(), 0);
    @(posedge clk); #2;
    load(0, 14, 0); load(1, 15, 0);
    expect_pkt(0, 14, 0); expect_pkt(1, 15, 0);
    wait_idle("post_reset");

    // Stats: 7 packets on link0, 3 on link1, from a fresh reset
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    for (int p = 0; p < 7; p++) load(0, 20 + p, 0);
    for (int p = 0; p < 3; p++) load(1, 30 + p, 1);
    for (int p = 0; p < 3; p++) begin
      expect_pkt(0, 20 + p, 0);
      expect_pkt(1, 30 + p, 1);
    end
    for (int p = 3; p < 7; p++) expect_pkt(0, 20 + p, 0);
    wait_idle("stats_traffic");
`ifdef BSG_GATEWAY_MEM_ARB_STATS_EN
    stats_exp = {32'd3, 32'd7};
`else
    stats_exp = '0;
`endif
    check("stats", stats, stats_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
